md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have the port start, input, 1 bit: operation strobe from the E stage; sampled on the rising edge.
REQ-004 The block SHALL have the port md_op, input, 3 bits: operation code. 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; other codes are no-ops.
REQ-005 The block SHALL have the port a, input, 32 bits: rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-006 The block SHALL have the port b, input, 32 bits: rt operand (divisor / multiplier).
REQ-007 The block SHALL have the port hi, output, 32 bits: architectural HI register, read by mfhi.
REQ-008 The block SHALL have the port lo, output, 32 bits: architectural LO register, read by mflo.
REQ-009 The block SHALL have the port MDbusy, output, 1 bit: busy indication consumed by the stall unit.

Function
REQ-010 The block SHALL accept a start only when busy_reg = 0; start while busy_reg = 1 SHALL be ignored entirely (no HI/LO write, no restart).
REQ-011 The block SHALL register a, b and md_op on an accepted start; later changes on a, b and md_op SHALL NOT affect the result.
REQ-012 mult/multu SHALL give a busy period N = 5 cycles; div/divu SHALL give N = 10 cycles.
REQ-013 On an accepted mult/multu/div/divu start, a 4-bit down-counter SHALL load N; busy_reg SHALL be 1 for exactly the N cycles after the start cycle.
REQ-014 The block SHALL write HI/LO on the rising edge where the counter goes 1 -> 0; busy_reg SHALL fall on that same edge.
REQ-015 The state machine SHALL have the states IDLE, MUL and DIV: IDLE -> MUL/DIV on an accepted start; MUL/DIV -> IDLE when the count expires.
REQ-016 MDbusy SHALL equal (start & md_op is mult/multu/div/divu) | busy_reg, combinationally, so that a dependent instruction stalls in the start cycle itself.
REQ-017 mthi/mtlo SHALL write a into hi/lo on the start edge, with 1-cycle effect and no busy period; MDbusy SHALL stay 0 for them.
REQ-018 Multiplication: {hi,lo} SHALL equal the 64-bit product; mult is signed two's-complement, multu is unsigned.
REQ-019 Division: lo SHALL be the quotient and hi the remainder; divu is unsigned. div is signed, with the quotient truncated toward zero and the remainder taking the sign of the dividend.
REQ-020 div 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-021 Division by zero SHALL follow REQ-026 / REQ-027; its latency SHALL be the normal 10 cycles.
REQ-022 Results SHALL be computed combinationally from the latched operands or iteratively; either choice is acceptable provided REQ-012 to REQ-014 timing holds exactly.

Reset
REQ-023 When reset = 0, hi = 0, lo = 0, busy_reg = 0, the counter = 0, state = IDLE and the latched operands = 0, all taking effect immediately without a clock.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no HI/LO write; after release the block SHALL be IDLE.
REQ-025 A start in the first edge after reset release SHALL be accepted normally.

Configuration
REQ-026 With macro MD_DIV0_GUARD_EN defined, div/divu with b = 0 SHALL leave hi/lo unchanged at completion, and the busy period SHALL still be 10 cycles.
REQ-027 Without MD_DIV0_GUARD_EN, div/divu with b = 0 SHALL write hi = latched a and lo = 0xFFFFFFFF, for both signed and unsigned division.

Verification
REQ-028 The bench SHALL cover: mult a=0xFFFFFFFF, b=2 -> MDbusy high in the start cycle plus 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. multu with the same operands -> hi = 0x00000001, lo = 0xFFFFFFFE.
REQ-029 The bench SHALL cover: div a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu a=7, b=2 -> lo = 3, hi = 1.
REQ-030 The bench SHALL cover: divu a=5, b=0 -> with MD_DIV0_GUARD_EN, hi/lo unchanged; without it, hi = 5, lo = 0xFFFFFFFF; both cases 10 busy cycles.
REQ-031 The bench SHALL cover: mult started, then in busy cycle 2 start with mtlo a=0x1234 -> ignored; final lo = the product; busy count unchanged.
REQ-032 The bench SHALL cover: reset driven low in cycle 3 of a div -> hi = lo = 0 and MDbusy = 0 immediately; the next div completes normally.
REQ-033 The bench SHALL cover: mthi a=0xDEADBEEF -> hi = 0xDEADBEEF after 1 edge, MDbusy = 0 throughout; then the div 0x80000000 / 0xFFFFFFFF case -> lo = 0x80000000, hi = 0.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit with HI/LO registers, 5-cycle mult and 10-cycle div busy periods.
// Optional MD_DIV0_GUARD_EN: divide by zero leaves HI/LO untouched instead of writing a / all-ones.
module md_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        MDbusy
);
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic        is_md, is_mul, sgn_m, sgn_d, a_neg, b_neg;
   logic [63:0] sa, sb, prod;
   logic [31:0] a_mag, b_mag, b_safe, uq, ur, quot, rem;
   assign is_md  = md_op >= 3'b001 && md_op <= 3'b100;
   assign is_mul = md_op == 3'b001 || md_op == 3'b010;
   assign MDbusy = (start & is_md) | busy_q;
   assign hi     = hi_q;
   assign lo     = lo_q;
   always_comb begin
      sgn_m  = op_q == 3'b001;
      sa     = {{32{sgn_m & a_q[31]}}, a_q};
      sb     = {{32{sgn_m & b_q[31]}}, b_q};
      prod   = sa * sb;
      sgn_d  = op_q == 3'b011;
      a_neg  = sgn_d & a_q[31];
      b_neg  = sgn_d & b_q[31];
      a_mag  = a_neg ? -a_q : a_q;
      b_mag  = b_neg ? -b_q : b_q;
      // b_safe only keeps the divider defined; the zero case is replaced below
      b_safe = b_mag == 32'd0 ? 32'd1 : b_mag;
      uq     = a_mag / b_safe;
      ur     = a_mag % b_safe;
      quot   = (a_neg ^ b_neg) ? -uq : uq;
      rem    = a_neg ? -ur : ur;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (!busy_q) begin
         if (start) begin
            op_d = md_op;
            a_d  = a;
            b_d  = b;
            if (is_md) begin
               state_d = is_mul ? MUL : DIV;
               cnt_d   = is_mul ? 4'd5 : 4'd10;
               busy_d  = 1'b1;
            end
            hi_d = md_op == 3'b101 ? a : hi_q;
            lo_d = md_op == 3'b110 ? a : lo_q;
         end
      end else begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (state_q == MUL) begin
               hi_d = prod[63:32];
               lo_d = prod[31:0];
            end else if (b_q != 32'd0) begin
               hi_d = rem;
               lo_d = quot;
            end else begin
`ifdef MD_DIV0_GUARD_EN
               hi_d = hi_q;
               lo_d = lo_q;
`else
               hi_d = a_q;
               lo_d = 32'hFFFF_FFFF;
`endif
            end
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit; honours MD_DIV0_GUARD_EN like the design.
module tb_md_unit;
   logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic [31:0] hi, lo;
   logic        MDbusy;
   int          total = 0, bad = 0;
   md_unit dut (.clk(clk), .reset(reset), .start(start), .md_op(md_op), .a(a), .b(b),
                .hi(hi), .lo(lo), .MDbusy(MDbusy));
   always #5 clk = ~clk;
   // Starts an op at a falling edge and counts MDbusy cycles including the start cycle;
   // inputs are scrambled afterwards so only latched operands can produce the result.
   task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv, output int n);
      @(negedge clk);
      start = 1'b1; md_op = op; a = av; b = bv;
      #1;
      n = 0;
      while (MDbusy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
         start = 1'b0; md_op = 3'd0; a = 32'hA5A5_A5A5; b = 32'd0;
         #1;
      end
   endtask
   task automatic test_reset();
      #2;
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
      total++; if (MDbusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", MDbusy); end
      @(negedge clk);
      reset = 1'b1;
   endtask
   task automatic test_mult();
      int n;
      run_op(3'b001, 32'hFFFF_FFFF, 32'd2, n);
      total++; if (n !== 6) begin bad++; $display("FAIL mult_busy got=%0d want=6", n); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
      total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got=%h want=fffffffe", lo); end
      run_op(3'b010, 32'hFFFF_FFFF, 32'd2, n);
      total++; if (n !== 6) begin bad++; $display("FAIL multu_busy got=%0d want=6", n); end
      total++; if (hi !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi got=%h want=00000001", hi); end
      total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h want=fffffffe", lo); end
   endtask
   task automatic test_div();
      int n;
      run_op(3'b011, 32'hFFFF_FFF9, 32'd2, n);
      total++; if (n !== 11) begin bad++; $display("FAIL div_busy got=%0d want=11", n); end
      total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
      total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
      run_op(3'b100, 32'd7, 32'd2, n);
      total++; if (n !== 11) begin bad++; $display("FAIL divu_busy got=%0d want=11", n); end
      total++; if (lo !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h want=3", lo); end
      total++; if (hi !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h want=1", hi); end
   endtask
   task automatic test_div0();
      int n;
      logic [31:0] ehi, elo;
      run_op(3'b100, 32'd5, 32'd0, n);
`ifdef MD_DIV0_GUARD_EN
      ehi = 32'd1; elo = 32'd3;
`else
      ehi = 32'd5; elo = 32'hFFFF_FFFF;
`endif
      total++; if (n !== 11) begin bad++; $display("FAIL divu0_busy got=%0d want=11", n); end
      total++; if (hi !== ehi) begin bad++; $display("FAIL divu0_hi got=%h want=%h", hi, ehi); end
      total++; if (lo !== elo) begin bad++; $display("FAIL divu0_lo got=%h want=%h", lo, elo); end
      run_op(3'b011, 32'hFFFF_FFFD, 32'd0, n);
`ifndef MD_DIV0_GUARD_EN
      ehi = 32'hFFFF_FFFD;
`endif
      total++; if (n !== 11) begin bad++; $display("FAIL div0_busy got=%0d want=11", n); end
      total++; if (hi !== ehi) begin bad++; $display("FAIL div0_hi got=%h want=%h", hi, ehi); end
      total++; if (lo !== elo) begin bad++; $display("FAIL div0_lo got=%h want=%h", lo, elo); end
   endtask
   task automatic test_ignore();
      int n;
      @(negedge clk);
      start = 1'b1; md_op = 3'b001; a = 32'd3; b = 32'd4;
      #1;
      n = 0;
      while (MDbusy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
         start = (n == 2); md_op = n == 2 ? 3'b110 : 3'b000; a = n == 2 ? 32'h1234 : 32'd9; b = 32'd9;
         #1;
      end
      total++; if (n !== 6) begin bad++; $display("FAIL ignore_busy got=%0d want=6", n); end
      total++; if (lo !== 32'd12) begin bad++; $display("FAIL ignore_lo got=%h want=c", lo); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL ignore_hi got=%h want=0", hi); end
   endtask
   task automatic test_reset_mid();
      int n;
      @(negedge clk);
      start = 1'b1; md_op = 3'b011; a = 32'd100; b = 32'd7;
      repeat (3) @(negedge clk);
      start = 1'b0; md_op = 3'd0;
      total++; if (MDbusy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b want=1", MDbusy); end
      #1 reset = 1'b0;
      #1;
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL mid_hi got=%h want=0", hi); end
      total++; if (lo !== 32'd0) begin bad++; $display("FAIL mid_lo got=%h want=0", lo); end
      total++; if (MDbusy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", MDbusy); end
      @(posedge clk);
      #1 reset = 1'b1;
      run_op(3'b011, 32'd100, 32'd7, n);
      total++; if (n !== 11) begin bad++; $display("FAIL post_busy got=%0d want=11", n); end
      total++; if (lo !== 32'd14) begin bad++; $display("FAIL post_lo got=%h want=e", lo); end
      total++; if (hi !== 32'd2) begin bad++; $display("FAIL post_hi got=%h want=2", hi); end
   endtask
   task automatic test_mthi();
      int n;
      @(negedge clk);
      start = 1'b1; md_op = 3'b101; a = 32'hDEAD_BEEF; b = 32'd0;
      #1;
      total++; if (MDbusy !== 1'b0) begin bad++; $display("FAIL mthi_busy0 got=%b want=0", MDbusy); end
      @(negedge clk);
      start = 1'b0; md_op = 3'd0;
      #1;
      total++; if (hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mthi_hi got=%h want=deadbeef", hi); end
      total++; if (MDbusy !== 1'b0) begin bad++; $display("FAIL mthi_busy1 got=%b want=0", MDbusy); end
      run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, n);
      total++; if (n !== 11) begin bad++; $display("FAIL ovf_busy got=%0d want=11", n); end
      total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo got=%h want=80000000", lo); end
      total++; if (hi !== 32'd0) begin bad++; $display("FAIL ovf_hi got=%h want=0", hi); end
   endtask
   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div0();
      test_ignore();
      test_reset_mid();
      test_mthi();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
